// File: rtl/apb_master_nslv.sv
// APB master bridging a simple transfer/rw request port onto NUM_SLAVES address-decoded slaves.
// Latency: 3+W cycles accept-to-done (W = wait states), 2 for a decode error; req_ready low while busy, requests then ignored.
module apb_master_nslv #(
    parameter int DATA       = 32,
    parameter int ADDR       = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_LSB    = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       transfer,
    input  logic                       rw,
    input  logic [ADDR-1:0]            addr_in,
    input  logic [DATA-1:0]            data_in,
    input  logic [DATA/8-1:0]          strb_in,
    output logic                       req_ready,
    output logic                       done,
    output logic                       err,
    output logic [DATA-1:0]            rdata_out,
    output logic [ADDR-1:0]            paddr,
    output logic [NUM_SLAVES-1:0]      psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [DATA-1:0]            pwdata,
    output logic [DATA/8-1:0]          pstrb,
    input  logic [NUM_SLAVES*DATA-1:0] prdata_bus,
    input  logic [NUM_SLAVES-1:0]      pready,
    input  logic [NUM_SLAVES-1:0]      pslverr
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int NB = DATA / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           idx_q, idx_d;
    logic                    dec_err_q, dec_err_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    req_ready_q, req_ready_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [DATA-1:0]         rdata_q, rdata_d;
    logic [ADDR-1:0]         paddr_q, paddr_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA-1:0]         pwdata_q, pwdata_d;
    logic [NB-1:0]           pstrb_q, pstrb_d;

    logic [SW-1:0]           req_idx;
    logic                    req_ok;
    logic                    sel_ready;
    logic                    sel_slverr;
    logic [DATA-1:0]         sel_rdata;

    assign req_idx    = addr_in[SLV_LSB +: SW];
    assign sel_ready  = pready[idx_q];
    assign sel_slverr = pslverr[idx_q];
    assign sel_rdata  = prdata_bus[int'(idx_q)*DATA +: DATA];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dec_err_d   = dec_err_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        done_d      = 1'b0;
        err_d       = err_q;
        rdata_d     = rdata_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;

        req_ok = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (req_idx == SW'(i)) req_ok = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d     = SETUP;
                    req_ready_d = 1'b0;
                    idx_d       = req_idx;
                    dec_err_d   = !req_ok;
                    if (req_ok) begin
                        paddr_d  = addr_in;
                        pwrite_d = rw;
                        pwdata_d = data_in;
                        pstrb_d  = rw ? strb_in : '0;
                        for (int i = 0; i < NUM_SLAVES; i++) begin
                            psel_d[i] = (req_idx == SW'(i));
                        end
                    end
                end
            end
            // A decode error spends its SETUP cycle with no select asserted, so it
            // completes one cycle ahead of a zero-wait access.
            SETUP: begin
                if (dec_err_q) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    state_d   = ACCESS;
                    penable_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            ACCESS: begin
                if (sel_ready || (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d   = RESP;
                    done_d    = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (sel_ready) begin
                        err_d   = sel_slverr;
                        rdata_d = pwrite_q ? '0 : sel_rdata;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dec_err_q   <= 1'b0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            paddr_q     <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dec_err_q   <= dec_err_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
        end
    end

    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata_out = rdata_q;
    assign paddr     = paddr_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;

endmodule

// File: tb/tb_apb_master_nslv.sv
// Bench for apb_master_nslv: a 4-slave instance for the main traffic and a 3-slave instance for decode errors.
module tb_apb_master_nslv;

    localparam int TMO = 16;

    logic         pclk = 1'b0;
    logic         preset;
    logic         transfer, transfer3;
    logic         rw;
    logic [31:0]  addr_in, data_in;
    logic [3:0]   strb_in;
    logic [127:0] prdata_bus;
    logic [3:0]   pready, pslverr;

    logic         req_ready, done, err, penable, pwrite;
    logic [31:0]  rdata_out, paddr, pwdata;
    logic [3:0]   psel, pstrb;

    logic         req_ready3, done3, err3, penable3, pwrite3;
    logic [31:0]  rdata_out3, paddr3, pwdata3;
    logic [2:0]   psel3;
    logic [3:0]   pstrb3;

    bit           use3;
    logic         o_rdy, o_done, o_err, o_pen, o_pwr;
    logic [31:0]  o_rdata, o_paddr, o_pwdata;
    logic [3:0]   o_psel, o_pstrb;

    int vectors = 0;
    int miscompares = 0;

    always #5 pclk = ~pclk;

    apb_master_nslv #(.DATA(32), .ADDR(32), .NUM_SLAVES(4), .SLV_LSB(8), .TIMEOUT(TMO)) u_dut (
        .pclk(pclk), .preset(preset), .transfer(transfer), .rw(rw), .addr_in(addr_in),
        .data_in(data_in), .strb_in(strb_in), .req_ready(req_ready), .done(done), .err(err),
        .rdata_out(rdata_out), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata_bus(prdata_bus), .pready(pready), .pslverr(pslverr)
    );

    apb_master_nslv #(.DATA(32), .ADDR(32), .NUM_SLAVES(3), .SLV_LSB(8), .TIMEOUT(TMO)) u_dut3 (
        .pclk(pclk), .preset(preset), .transfer(transfer3), .rw(rw), .addr_in(addr_in),
        .data_in(data_in), .strb_in(strb_in), .req_ready(req_ready3), .done(done3), .err(err3),
        .rdata_out(rdata_out3), .paddr(paddr3), .psel(psel3), .penable(penable3), .pwrite(pwrite3),
        .pwdata(pwdata3), .pstrb(pstrb3), .prdata_bus(prdata_bus[95:0]), .pready(pready[2:0]),
        .pslverr(pslverr[2:0])
    );

    always_comb begin
        if (use3) begin
            o_rdy = req_ready3; o_done = done3; o_err = err3; o_pen = penable3; o_pwr = pwrite3;
            o_rdata = rdata_out3; o_paddr = paddr3; o_pwdata = pwdata3;
            o_psel = {1'b0, psel3}; o_pstrb = pstrb3;
        end else begin
            o_rdy = req_ready; o_done = done; o_err = err; o_pen = penable; o_pwr = pwrite;
            o_rdata = rdata_out; o_paddr = paddr; o_pwdata = pwdata;
            o_psel = psel; o_pstrb = pstrb;
        end
    end

    // One request, checked against the transaction-level model: a slave that raises
    // pready on access cycle waits+1 (never, if waits >= TMO), an APB address window
    // of 256 bytes per slave, and fixed accept-to-done latencies.
    task automatic run_txn(input bit u3, input logic [31:0] a, input bit w, input logic [31:0] d,
                           input logic [3:0] s, input int waits, input bit serr,
                           input logic [31:0] rd, input bit hold);
        int n, idx, exp_acc, exp_lat, c, acc;
        bit dec, tmo, exp_err, got;
        logic [31:0] exp_rd;
        logic [3:0]  exp_psel, exp_strb;
        n        = u3 ? 3 : 4;
        idx      = int'((a >> 8) & 32'h3);
        dec      = (idx >= n);
        tmo      = !dec && (waits >= TMO);
        exp_acc  = dec ? 0 : (tmo ? TMO : waits + 1);
        exp_lat  = dec ? 2 : 2 + exp_acc;
        exp_err  = dec || tmo || serr;
        exp_rd   = (!w && !dec && !tmo) ? rd : 32'h0;
        exp_psel = 4'b0001 << idx;
        exp_strb = w ? s : 4'h0;

        use3 = u3; rw = w; addr_in = a; data_in = d; strb_in = s;
        for (int i = 0; i < 4; i++) prdata_bus[i*32 +: 32] = (i == idx) ? rd : $urandom;
        pready = 4'($urandom); pslverr = 4'($urandom);
        #1;
        vectors++;
        if (o_rdy !== 1'b1) begin
            miscompares++; $display("FAIL req_ready_idle: got %b want 1", o_rdy);
        end
        if (u3) transfer3 = 1'b1; else transfer = 1'b1;

        c = 0; acc = 0; got = 0;
        while (!got && c < 60) begin
            @(negedge pclk);
            c++;
            if (c == 1) begin
                if (!hold) begin transfer = 1'b0; transfer3 = 1'b0; end
                else begin addr_in = a ^ 32'h0000_0100; data_in = $urandom; rw = ~w; end
            end
            if (o_psel !== 4'h0) begin
                vectors++;
                if (dec || {o_psel, o_paddr, o_pwr, o_pstrb} !== {exp_psel, a, w, exp_strb}) begin
                    miscompares++;
                    $display("FAIL apb_sigs c=%0d: got psel=%b paddr=%h pwrite=%b pstrb=%h want psel=%b paddr=%h pwrite=%b pstrb=%h dec=%0b",
                             c, o_psel, o_paddr, o_pwr, o_pstrb, exp_psel, a, w, exp_strb, dec);
                end
                if (w) begin
                    vectors++;
                    if (o_pwdata !== d) begin
                        miscompares++; $display("FAIL pwdata: got %h want %h", o_pwdata, d);
                    end
                end
            end
            if (o_pen === 1'b1) begin
                acc++;
                vectors++;
                if (o_psel === 4'h0) begin
                    miscompares++; $display("FAIL penable_without_psel: got psel=%b want nonzero", o_psel);
                end
            end
            pready = 4'($urandom); pslverr = 4'($urandom);
            if (o_pen === 1'b1) pready[idx] = (acc == waits + 1);
            if (pready[idx]) pslverr[idx] = serr;
            if (o_done === 1'b1) got = 1;
        end
        transfer = 1'b0; transfer3 = 1'b0;

        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL done_timeout: got no done in %0d cycles want done at %0d", c, exp_lat);
        end
        vectors++;
        if (c !== exp_lat) begin
            miscompares++; $display("FAIL latency: got %0d want %0d", c, exp_lat);
        end
        vectors++;
        if (acc !== exp_acc) begin
            miscompares++; $display("FAIL access_cycles: got %0d want %0d", acc, exp_acc);
        end
        vectors++;
        if ({o_err, o_rdata} !== {exp_err, exp_rd}) begin
            miscompares++; $display("FAIL resp: got err=%b rdata=%h want err=%b rdata=%h", o_err, o_rdata, exp_err, exp_rd);
        end
        vectors++;
        if ({o_psel, o_pen} !== 5'b0) begin
            miscompares++; $display("FAIL resp_bus_idle: got psel=%b penable=%b want 0", o_psel, o_pen);
        end

        @(negedge pclk);
        vectors++;
        if ({o_done, o_rdy, o_psel, o_err, o_rdata} !== {1'b0, 1'b1, 4'h0, exp_err, exp_rd}) begin
            miscompares++;
            $display("FAIL after_done: got done=%b rdy=%b psel=%b err=%b rdata=%h want done=0 rdy=1 psel=0 err=%b rdata=%h",
                     o_done, o_rdy, o_psel, o_err, o_rdata, exp_err, exp_rd);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        vectors++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb, done, err, rdata_out, req_ready} !==
            {4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL %s: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%h done=%b err=%b rdata=%h rdy=%b want all 0, rdy=1",
                     tag, psel, penable, pwrite, paddr, pwdata, pstrb, done, err, rdata_out, req_ready);
        end
    endtask

    task automatic test_reset();
        preset = 1'b1; transfer = 1'b0; transfer3 = 1'b0; use3 = 1'b0;
        rw = 1'b0; addr_in = '0; data_in = '0; strb_in = '0;
        prdata_bus = '0; pready = '0; pslverr = '0;
        repeat (2) @(negedge pclk);
        check_reset_vals("reset_state");
        preset = 1'b0;
        @(negedge pclk);
        check_reset_vals("after_release");
    endtask

    task automatic test_zero_wait_wr_rd();
        run_txn(0, 32'h0000_0104, 1, 32'hAAAA_5555, 4'hF, 0, 0, 32'h0, 0);
        run_txn(0, 32'h0000_0104, 0, 32'h1234_5678, 4'hF, 0, 0, 32'hAAAA_5555, 0);
    endtask

    task automatic test_wait_states();
        run_txn(0, 32'h0000_0208, 0, 32'h0, 4'h0, 3, 0, $urandom, 0);
    endtask

    task automatic test_slave_error();
        run_txn(0, 32'h0000_030C, 1, $urandom, 4'h3, 0, 1, 32'h0, 0);
        run_txn(0, 32'h0000_0010, 0, 32'h0, 4'h0, 1, 0, $urandom, 0);
    endtask

    task automatic test_decode_error();
        run_txn(1, 32'h0000_0300, 0, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 0);
        run_txn(1, 32'h0000_0204, 0, 32'h0, 4'h0, 1, 0, $urandom, 0);
    endtask

    task automatic test_timeout();
        run_txn(0, 32'h0000_0000, 0, 32'h0, 4'h0, 1000, 0, 32'h5A5A_A5A5, 0);
        run_txn(0, 32'h0000_0040, 1, 32'hCAFE_F00D, 4'h5, 2, 0, 32'h0, 0);
    endtask

    task automatic test_busy_ignored();
        run_txn(0, 32'h0000_0120, 0, 32'h0, 4'h0, 2, 0, $urandom, 1);
        @(negedge pclk);
        vectors++;
        if ({o_rdy, o_psel} !== {1'b1, 4'h0}) begin
            miscompares++; $display("FAIL busy_not_queued: got rdy=%b psel=%b want rdy=1 psel=0", o_rdy, o_psel);
        end
    endtask

    task automatic test_reset_mid_access();
        int k;
        use3 = 0; rw = 1'b1; addr_in = 32'h0000_0004; data_in = $urandom; strb_in = 4'hF;
        pready = 4'h0; pslverr = 4'h0;
        transfer = 1'b1;
        k = 0;
        while (penable !== 1'b1 && k < 10) begin
            @(negedge pclk); k++; transfer = 1'b0;
        end
        vectors++;
        if (penable !== 1'b1) begin
            miscompares++; $display("FAIL reach_access: got penable=%b want 1", penable);
        end
        @(negedge pclk);
        #2 preset = 1'b1;
        #1;
        vectors++;
        if ({psel, penable, done, req_ready} !== {4'h0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: got psel=%b pen=%b done=%b rdy=%b want 0 0 0 1", psel, penable, done, req_ready);
        end
        @(negedge pclk);
        preset = 1'b0;
        repeat (2) begin
            @(negedge pclk);
            vectors++;
            if ({done, req_ready, psel} !== {1'b0, 1'b1, 4'h0}) begin
                miscompares++; $display("FAIL post_reset_idle: got done=%b rdy=%b psel=%b want 0 1 0", done, req_ready, psel);
            end
        end
        run_txn(0, 32'h0000_0108, 1, 32'h0BAD_F00D, 4'hC, 0, 0, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        run_txn(0, 32'h0000_0300, 1, $urandom, 4'hA, 0, 0, 32'h0, 0);
        run_txn(0, 32'h0000_0300, 0, 32'h0, 4'h0, 0, 0, $urandom, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            bit u3;
            u3 = ($urandom_range(0, 3) == 0);
            run_txn(u3, {20'h0, 2'($urandom), 10'($urandom)}, 1'($urandom), $urandom, 4'($urandom),
                    ($urandom_range(0, 9) == 0) ? TMO + 5 : $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0), $urandom, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_wr_rd();
        test_wait_states();
        test_slave_error();
        test_decode_error();
        test_timeout();
        test_busy_ignored();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
